// File: rtl/ciclo_rampa_gen_pkg.sv
// Shared definitions for the duty-cycle ramp generator: FSM state encoding
// and the default duty/counter width.
package ciclo_rampa_gen_pkg;

  localparam int DEFAULT_R = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_TOP  = 3'd2,
    ST_DOWN = 3'd3,
    ST_BOT  = 3'd4
  } ramp_state_t;

endpackage

// File: rtl/ciclo_rampa_gen_periodo_tick.sv
// Free-running PWM period counter plus the duty-update strobe. The counter
// leaves reset at zero on the same edge as pwm_basico, so both stay aligned.
module ciclo_rampa_gen_periodo_tick #(
  parameter int R            = 8,
  parameter int STEP_PERIODS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic period_tick,
  output logic upd
);

  localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [R-1:0]  PRE_MAX  = {{(R-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] PER_LAST = PW'(STEP_PERIODS - 1);

  logic [R-1:0]  cnt;
  logic [PW-1:0] per_cnt;

  // Period counter; the tick is registered so it is high exactly while cnt == MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_tick <= (cnt == PRE_MAX);
    end
  end

  // Counts whole PWM periods between duty updates; held at zero while the ramp is idle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      per_cnt <= '0;
    end else if (period_tick) begin
      per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
    end
  end

  assign upd = period_tick & (per_cnt == PER_LAST);

endmodule

// File: rtl/ciclo_rampa_gen.sv
// Duty-cycle ramp generator feeding pwm_basico. Sweeps the duty word in a
// triangle or sawtooth profile, changing it only at PWM period boundaries.
module ciclo_rampa_gen
  import ciclo_rampa_gen_pkg::*;
#(
  parameter int R            = DEFAULT_R,
  parameter int STEP_PERIODS = 4,
  parameter int DWELL        = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         modo,
  input  logic [R-1:0] paso,
  output logic [R-1:0] ciclo,
  output logic         period_tick,
  output logic         subiendo
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [R-1:0]  MAX        = {R{1'b1}};
  localparam logic [R:0]    MAX_EXT    = {1'b0, MAX};

  ramp_state_t   state, state_nxt;
  logic [R-1:0]  ciclo_nxt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic          upd;
  logic [R-1:0]  paso_eff;
  logic [R:0]    suma;

  ciclo_rampa_gen_periodo_tick #(
    .R            (R),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_periodo_tick (
    .clk         (clk),
    .reset       (reset),
    .clr         (state == ST_IDLE),
    .period_tick (period_tick),
    .upd         (upd)
  );

  // A zero step would stall the ramp forever, so it behaves as a step of one.
  assign paso_eff = (paso == '0) ? R'(1) : paso;
  assign suma     = {1'b0, ciclo} + {1'b0, paso_eff};
  assign subiendo = (state == ST_UP) || (state == ST_TOP);

  // State, duty word and dwell counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ciclo     <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ciclo     <= ciclo_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

  // Next-state and duty arithmetic; dropping enable always parks in IDLE with the duty frozen.
  always_comb begin
    state_nxt = state;
    ciclo_nxt = ciclo;
    dwell_nxt = dwell_cnt;
    case (state)
      ST_IDLE: begin
        dwell_nxt = '0;
        if (enable) state_nxt = ST_UP;
      end
      ST_UP: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (upd) begin
          if (suma >= MAX_EXT) begin
            ciclo_nxt = MAX;
            dwell_nxt = '0;
            state_nxt = ST_TOP;
          end else begin
            ciclo_nxt = suma[R-1:0];
          end
        end
      end
      ST_TOP: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (upd) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_nxt = '0;
            if (modo) begin
              ciclo_nxt = '0;
              state_nxt = ST_BOT;
            end else begin
              state_nxt = ST_DOWN;
            end
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
      end
      ST_DOWN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (upd) begin
          if (ciclo <= paso_eff) begin
            ciclo_nxt = '0;
            dwell_nxt = '0;
            state_nxt = ST_BOT;
          end else begin
            ciclo_nxt = ciclo - paso_eff;
          end
        end
      end
      ST_BOT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (upd) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_nxt = '0;
            state_nxt = ST_UP;
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
